// File: rtl/calc_pkg.sv
// Shared types and default parameters for the request-scheduled multiply-add unit.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ADD  = 2'd2,
      RESP = 2'd3
   } calc_state_e;

   localparam int CALC_WIDTH_DEF  = 8;
   localparam int CALC_OFFSET_DEF = 5;

endpackage

// File: rtl/calc_req_scheduler_if.sv
// Requester and response bundle for calc_req_scheduler; slave is the scheduler side.
interface calc_req_scheduler_if
   import calc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = CALC_WIDTH_DEF
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [IDW-1:0]           resp_id;
   logic [WIDTH-1:0]         resp_data;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_id, resp_data
   );

endinterface

// File: rtl/calc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, which moves past
// the winner only when the grant is actually taken (advance).
module calc_rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_r;

   // Priority search starting at the pointer, wrapping modulo N.
   always_comb begin
      int   j;
      logic hit;
      grant     = '0;
      grant_idx = '0;
      hit       = 1'b0;
      j         = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr_r) + i) % N;
         if (!hit && req[j]) begin
            grant[j]  = 1'b1;
            grant_idx = IW'(j);
            hit       = 1'b1;
         end else begin
            hit = hit;
         end
      end
   end

   // Pointer register: next priority goes to the requester after the winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (advance) begin
         ptr_r <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/calc_req_scheduler.sv
// Shares one shift-add multiplier between NUM_REQ requesters, returning a*b+OFFSET.
// Build option CALC_SAT_EN: saturate the result instead of wrapping it.
module calc_req_scheduler
   import calc_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = CALC_WIDTH_DEF,
   parameter int OFFSET  = CALC_OFFSET_DEF
)(
   input  logic                 clk,
   input  logic                 rst_n,
   calc_req_scheduler_if.slave  bus,
   output logic                 busy
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = 2 * WIDTH;
   localparam int CW  = $clog2(WIDTH);

   calc_state_e          state_r, state_s;
   logic [NUM_REQ-1:0]   grant_s;
   logic [IDW-1:0]       gidx_s;
   logic                 idle_s, accept_s;
   logic [WIDTH-1:0]     a_sel_s, b_sel_s;
   logic [PW-1:0]        mcand_r, prod_r;
   logic [WIDTH-1:0]     mplier_r;
   logic [CW-1:0]        cnt_r;
   logic [IDW-1:0]       id_r, resp_id_r;
   logic [WIDTH-1:0]     resp_data_r, result_s;

   // rst_n gating keeps req_ready low while reset is held even if requests are pending.
   assign idle_s   = (state_r == IDLE) && rst_n;
   assign accept_s = idle_s && (|bus.req_valid);
   assign a_sel_s  = bus.req_a[int'(gidx_s)*WIDTH +: WIDTH];
   assign b_sel_s  = bus.req_b[int'(gidx_s)*WIDTH +: WIDTH];

   calc_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (bus.req_valid),
      .advance   (accept_s),
      .grant     (grant_s),
      .grant_idx (gidx_s)
   );

   assign bus.req_ready  = idle_s ? grant_s : {NUM_REQ{1'b0}};
   assign bus.resp_valid = (state_r == RESP);
   assign bus.resp_data  = resp_data_r;
   assign bus.resp_id    = resp_id_r;
   assign busy           = (state_r != IDLE);

   // Final offset add and width reduction of the full product.
   always_comb begin
`ifdef CALC_SAT_EN
      logic [PW:0] sum_v;
      sum_v = {1'b0, prod_r} + (PW + 1)'(OFFSET);
      if (|sum_v[PW:WIDTH]) begin
         result_s = {WIDTH{1'b1}};
      end else begin
         result_s = sum_v[WIDTH-1:0];
      end
`else
      result_s = prod_r[WIDTH-1:0] + WIDTH'(OFFSET);
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; MUL always runs exactly WIDTH steps.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = MUL;
            else          state_s = IDLE;
         end
         MUL: begin
            if (cnt_r == CW'(WIDTH - 1)) state_s = ADD;
            else                         state_s = MUL;
         end
         ADD:  state_s = RESP;
         RESP: begin
            if (bus.resp_ready) state_s = IDLE;
            else                state_s = RESP;
         end
         default: state_s = IDLE;
      endcase
   end

   // Operand capture, shift-add steps and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r     <= '0;
         mplier_r    <= '0;
         prod_r      <= '0;
         cnt_r       <= '0;
         id_r        <= '0;
         resp_data_r <= '0;
         resp_id_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  mcand_r  <= {{WIDTH{1'b0}}, a_sel_s};
                  mplier_r <= b_sel_s;
                  prod_r   <= '0;
                  cnt_r    <= '0;
                  id_r     <= gidx_s;
               end
            end
            MUL: begin
               if (mplier_r[0]) prod_r <= prod_r + mcand_r;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + 1'b1;
            end
            ADD: begin
               resp_data_r <= result_s;
               resp_id_r   <= id_r;
            end
            default: begin
               resp_data_r <= resp_data_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_req_scheduler.sv
// Directed-vector bench for calc_req_scheduler (NUM_REQ=4, WIDTH=8, OFFSET=5).
module tb_calc_req_scheduler;

   logic clk;
   logic rst_n;
   logic busy;
   int   n_vec;
   int   n_err;

   calc_req_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

   calc_req_scheduler #(.NUM_REQ(4), .WIDTH(8), .OFFSET(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[i*8 +: 8] = a;
      bus.req_b[i*8 +: 8] = b;
   endtask

   // Called at a negedge right after the accept edge; returns edges until resp_valid.
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!bus.resp_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("resp_seen", bus.resp_valid, 1);
   endtask

   // Full transaction with resp_ready high; starts and ends at a negedge in IDLE.
   task automatic single(input string tag, input int id, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d);
      int lat;
      set_op(id, a, b);
      bus.req_valid = 4'b0001 << id;
      #1;
      chk({tag, "_ready"}, bus.req_ready, 32'd1 << id);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      wait_resp(lat);
      chk({tag, "_lat"}, lat, 9);
      chk({tag, "_data"}, bus.resp_data, exp_d);
      chk({tag, "_id"}, bus.resp_id, id);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_vld_drop"}, bus.resp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rr_d [4];
      int lat;
      int w;
      n_vec = 0;
      n_err = 0;
      rst_n          = 1'b0;
      bus.req_valid  = 4'b0000;
      bus.req_a      = 32'd0;
      bus.req_b      = 32'd0;
      bus.resp_ready = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_valid", bus.resp_valid, 0);
      chk("rst_data", bus.resp_data, 0);
      chk("rst_id", bus.resp_id, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // Round robin with all four requesters held valid
      rr_d[0] = 8'd11; rr_d[1] = 8'd17; rr_d[2] = 8'd25; rr_d[3] = 8'd35;
      for (int i = 0; i < 4; i++) set_op(i, 8'(i + 2), 8'(i + 3));
      bus.req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 5; k++) begin
         w = 0;
         while (bus.req_ready == 4'b0000 && w < 30) begin
            @(posedge clk);
            @(negedge clk);
            w++;
         end
         chk("rr_grant", bus.req_ready, 32'd1 << (k % 4));
         @(posedge clk);
         @(negedge clk);
         chk("rr_pulse", bus.req_ready, 0);
         chk("rr_busy", busy, 1);
         wait_resp(lat);
         chk("rr_id", bus.resp_id, k % 4);
         chk("rr_data", bus.resp_data, rr_d[k % 4]);
      end
      bus.req_valid = 4'b0000;
      @(posedge clk);
      @(negedge clk);

      // Requester 1: 8*3+5
      single("r1", 1, 8'd8, 8'd3, 8'd29);

      // Stall in RESP with a pending request from requester 0
      bus.resp_ready = 1'b0;
      set_op(3, 8'd10, 8'd10);
      bus.req_valid = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      wait_resp(lat);
      set_op(0, 8'd1, 8'd1);
      bus.req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("stall_vld", bus.resp_valid, 1);
         chk("stall_data", bus.resp_data, 105);
         chk("stall_id", bus.resp_id, 3);
         chk("stall_ready", bus.req_ready, 0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_stall_vld", bus.resp_valid, 0);
      chk("post_stall_grant", bus.req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      wait_resp(lat);
      chk("post_stall_data", bus.resp_data, 6);
      chk("post_stall_id", bus.resp_id, 0);
      @(posedge clk);
      @(negedge clk);

      // Overflow and zero-operand corners
`ifdef CALC_SAT_EN
      single("max", 1, 8'd255, 8'd255, 8'd255);
`else
      single("max", 1, 8'd255, 8'd255, 8'd6);
`endif
      single("a_zero", 2, 8'd0, 8'd200, 8'd5);
      single("b_zero", 3, 8'd1, 8'd0, 8'd5);

      // Reset during the 4th MUL cycle aborts; index 0 wins afterwards
      set_op(2, 8'd3, 8'd4);
      bus.req_valid = 4'b0100;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      set_op(0, 8'd7, 8'd9);
      bus.req_valid = 4'b1101;
      #1;
      chk("abort_ready", bus.req_ready, 0);
      chk("abort_vld", bus.resp_valid, 0);
      chk("abort_data", bus.resp_data, 0);
      chk("abort_id", bus.resp_id, 0);
      chk("abort_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("abort_no_resp", bus.resp_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("rearm_grant", bus.req_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 4'b0000;
      wait_resp(lat);
      chk("rearm_lat", lat, 9);
      chk("rearm_id", bus.resp_id, 0);
      chk("rearm_data", bus.resp_data, 68);
      @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
